// File: rtl/dma_pkg.sv
// ============================================================================
// dma_pkg : shared state encoding and register map for the sprite OAM DMA.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam logic [23:0] OAMDMA_REG  = 24'h004014;
    localparam logic [23:0] OAMDATA_REG = 24'h002004;
    localparam int unsigned XFER_LEN    = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
// ============================================================================
// oam_dma_ctrl : halts the CPU and copies one page to OAMDATA on a $4014 write.
// Optional macro OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN state.
// Revision: 1.0
// ============================================================================
`default_nettype none

module oam_dma_ctrl
    import dma_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CPU_CE,
    input  logic [23:0] CPU_ADDR,
    input  logic        CPU_WE,
    input  logic [7:0]  CPU_DO,
    input  logic [7:0]  BUS_DI,
    output logic        CPU_RDY,
    output logic        DMA_ACTIVE,
    output logic [23:0] DMA_ADDR,
    output logic        DMA_WE,
    output logic [7:0]  DMA_DO
);

    localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       align_req;

`ifdef OAM_DMA_ALIGN_EN
    logic parity_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            parity_q <= 1'b0;
        else if (CPU_CE)
            parity_q <= ~parity_q;
    end

    // HALT moves to ALIGN when parity is 1 after the HALT edge, i.e. 0 before it.
    assign align_req = ~parity_q;
`else
    assign align_req = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (CPU_CE) begin
            case (state_q)
                IDLE: begin
                    if (CPU_WE && (CPU_ADDR == OAMDMA_REG)) begin
                        page_d  = CPU_DO;
                        state_d = HALT;
                    end
                end
                HALT:  state_d = align_req ? ALIGN : READ;
                ALIGN: state_d = READ;
                READ: begin
                    data_d  = BUS_DI;
                    state_d = WRITE;
                end
                WRITE: begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = 8'h00;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 8'h01;
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        CPU_RDY    = 1'b1;
        DMA_ACTIVE = 1'b0;
        DMA_ADDR   = 24'h000000;
        DMA_WE     = 1'b0;
        DMA_DO     = 8'h00;
        case (state_q)
            HALT: CPU_RDY = 1'b0;
            ALIGN, READ: begin
                CPU_RDY    = 1'b0;
                DMA_ACTIVE = 1'b1;
                DMA_ADDR   = {8'h00, page_q, idx_q};
            end
            WRITE: begin
                CPU_RDY    = 1'b0;
                DMA_ACTIVE = 1'b1;
                DMA_ADDR   = OAMDATA_REG;
                DMA_WE     = 1'b1;
                DMA_DO     = data_q;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
// ============================================================================
// tb_oam_dma_ctrl : self-checking bench for oam_dma_ctrl (either macro build).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_oam_dma_ctrl;
    import dma_pkg::*;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        CPU_CE = 1'b0;
    logic [23:0] CPU_ADDR = 24'h0;
    logic        CPU_WE = 1'b0;
    logic [7:0]  CPU_DO = 8'h0;
    logic [7:0]  BUS_DI;
    logic        CPU_RDY;
    logic        DMA_ACTIVE;
    logic [23:0] DMA_ADDR;
    logic        DMA_WE;
    logic [7:0]  DMA_DO;

    int checks = 0;
    int errors = 0;
    int ce_edges = 0;

    typedef struct packed {
        logic        rdy;
        logic        act;
        logic [23:0] addr;
        logic        we;
        logic [7:0]  dout;
    } bus_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  dout;
        logic        exp_rdy;
        logic        exp_act;
    } vec_t;

    localparam bus_t IDLE_BUS = '{rdy: 1'b1, act: 1'b0, addr: 24'h0, we: 1'b0, dout: 8'h0};

    oam_dma_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CPU_CE     (CPU_CE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WE     (CPU_WE),
        .CPU_DO     (CPU_DO),
        .BUS_DI     (BUS_DI),
        .CPU_RDY    (CPU_RDY),
        .DMA_ACTIVE (DMA_ACTIVE),
        .DMA_ADDR   (DMA_ADDR),
        .DMA_WE     (DMA_WE),
        .DMA_DO     (DMA_DO)
    );

    always #5 Clk = ~Clk;

    // Source memory: page $02 holds i^$5A; other pages are mixed with the page number.
    function automatic logic [7:0] src_byte(input logic [23:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    assign BUS_DI = DMA_ACTIVE ? src_byte(DMA_ADDR) : 8'hFF;

    task automatic tick(input logic ce);
        CPU_CE = ce;
        @(posedge Clk);
        if (Reset) ce_edges = 0;
        else if (ce) ce_edges++;
        #1;
    endtask

    task automatic check_bus(input string name, input bus_t exp);
        bus_t got;
        got = '{rdy: CPU_RDY, act: DMA_ACTIVE, addr: DMA_ADDR, we: DMA_WE, dout: DMA_DO};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got rdy=%0b act=%0b addr=%h we=%0b do=%h expected rdy=%0b act=%0b addr=%h we=%0b do=%h",
                     name, got.rdy, got.act, got.addr, got.we, got.dout,
                     exp.rdy, exp.act, exp.addr, exp.we, exp.dout);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Idle CE pulses until the next trigger lands with the requested HALT-edge parity.
    task automatic set_phase(input int odd);
        for (int n = 0; n < 4 && (((ce_edges + 2) % 2) != odd); n++) tick(1'b1);
    endtask

    // Full transfer of one page; abort_at >= 0 asserts Reset on that CE cycle instead.
    task automatic do_transfer(input string tag, input logic [7:0] page,
                               input int stall, input int abort_at);
        bus_t exp_q[$];
        bit   al;
        int   low;
        int   writes;
        low    = 0;
        writes = 0;
        al = ALIGN_EN && (((ce_edges + 2) % 2) == 1);
        exp_q.push_back('{rdy: 1'b0, act: 1'b0, addr: 24'h0, we: 1'b0, dout: 8'h0});
        if (al)
            exp_q.push_back('{rdy: 1'b0, act: 1'b1, addr: {8'h00, page, 8'h00}, we: 1'b0, dout: 8'h0});
        for (int i = 0; i < XFER_LEN; i++) begin
            exp_q.push_back('{rdy: 1'b0, act: 1'b1, addr: {8'h00, page, 8'(i)}, we: 1'b0, dout: 8'h0});
            exp_q.push_back('{rdy: 1'b0, act: 1'b1, addr: OAMDATA_REG, we: 1'b1,
                              dout: src_byte({8'h00, page, 8'(i)})});
        end
        exp_q.push_back(IDLE_BUS);

        CPU_WE = 1'b1; CPU_ADDR = OAMDMA_REG; CPU_DO = page;
        tick(1'b1);
        CPU_WE = 1'b0; CPU_ADDR = 24'h0; CPU_DO = 8'h0;

        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == abort_at) begin
                Reset = 1'b1;
                tick(1'b1);
                Reset = 1'b0;
                check_bus({tag, "_after_reset"}, IDLE_BUS);
                tick(1'b1);
                check_bus({tag, "_after_reset_idle"}, IDLE_BUS);
                return;
            end
            check_bus($sformatf("%s_cyc%0d", tag, k), exp_q[k]);
            if (k == exp_q.size() - 1) break;
            if (!CPU_RDY) low++;
            if (DMA_WE) writes++;
            for (int s = 0; s < stall; s++) begin
                tick(1'b0);
                check_bus($sformatf("%s_stall%0d", tag, k), exp_q[k]);
            end
            tick(1'b1);
        end
        check_val({tag, "_rdy_low_ce"}, low, al ? 514 : 513);
        check_val({tag, "_writes"}, writes, XFER_LEN);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{we: 1'b1, addr: 24'h004015, dout: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0};
        vecs[1] = '{we: 1'b1, addr: 24'h004016, dout: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 24'h004014, dout: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0};
        vecs[3] = '{we: 1'b1, addr: 24'h002004, dout: 8'h33, exp_rdy: 1'b1, exp_act: 1'b0};
        vecs[4] = '{we: 1'b1, addr: 24'h014014, dout: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0};
        vecs[5] = '{we: 1'b1, addr: 24'h004013, dout: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0};

        Reset = 1'b1;
        tick(1'b1);
        tick(1'b0);
        check_bus("reset_state", IDLE_BUS);
        Reset = 1'b0;
        tick(1'b0);
        check_bus("post_reset_idle", IDLE_BUS);

        foreach (vecs[v]) begin
            CPU_WE = vecs[v].we; CPU_ADDR = vecs[v].addr; CPU_DO = vecs[v].dout;
            tick(1'b1);
            CPU_WE = 1'b0; CPU_ADDR = 24'h0;
            check_val($sformatf("nontrig%0d_rdy", v), int'(CPU_RDY), int'(vecs[v].exp_rdy));
            check_val($sformatf("nontrig%0d_act", v), int'(DMA_ACTIVE), int'(vecs[v].exp_act));
            tick(1'b1);
            check_val($sformatf("nontrig%0d_rdy2", v), int'(CPU_RDY), int'(vecs[v].exp_rdy));
        end

        set_phase(0);
        do_transfer("even", 8'h02, 0, -1);
        set_phase(1);
        do_transfer("odd", 8'h02, 0, -1);
        set_phase(0);
        do_transfer("stall", 8'h02, 2, -1);
        set_phase(1);
        do_transfer("abort", 8'h02, 0, 100);
        do_transfer("fresh", 8'h03, 0, -1);
        do_transfer("io_page", 8'h40, 0, -1);

        for (int r = 0; r < 4; r++) begin
            int pre;
            pre = $urandom_range(0, 3);
            for (int p = 0; p < pre; p++) tick(1'($urandom_range(0, 1)));
            do_transfer($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)),
                        $urandom_range(0, 2), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
